// File: rtl/vend_pkg.sv
// Shared definitions for the multi-drink vending machine.
//   state_t        : controller states
//   COIN_*         : accepted coin denominations
//   is_legal_coin  : true for an accepted denomination
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   localparam int unsigned COIN_1  = 1;
   localparam int unsigned COIN_5  = 5;
   localparam int unsigned COIN_10 = 10;
   localparam int unsigned COIN_50 = 50;

   function automatic logic is_legal_coin(input int unsigned value);
      return (value == COIN_1) || (value == COIN_5) ||
             (value == COIN_10) || (value == COIN_50);
   endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change selector: largest denomination not exceeding the remainder.
//   remainder   : credit still owed
//   next_coin_c : coin to emit next (0 when nothing is owed)
module vend_change_gen
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W = 7
) (
   input  logic [CREDIT_W-1:0] remainder,
   output logic [CREDIT_W-1:0] next_coin_c
);

   always_comb begin
      next_coin_c = '0;
      if (remainder >= CREDIT_W'(COIN_50))      next_coin_c = CREDIT_W'(COIN_50);
      else if (remainder >= CREDIT_W'(COIN_10)) next_coin_c = CREDIT_W'(COIN_10);
      else if (remainder >= CREDIT_W'(COIN_5))  next_coin_c = CREDIT_W'(COIN_5);
      else if (remainder != '0)                 next_coin_c = CREDIT_W'(COIN_1);
   end

endmodule

// File: rtl/auto_vendor_multi.sv
// Multi-drink vending controller: credit accumulation, vend, greedy change.
// Optional macro VEND_CANCEL_EN adds input cancel (return full credit from CREDIT).
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   coin_valid, coin              : coin strobe and value
//   drink_req, drink_sel, restock : vend request / refill for drink_sel
//   total_coin                    : current credit
//   coin_reject, drink_out, vend_deny : one-cycle pulses
//   drink_id                      : last dispensed drink
//   refund_valid, refund          : change coin (refund is 0 when not valid)
//   sold_out                      : per-drink empty flags
//   busy                          : high in VEND or CHANGE
module auto_vendor_multi
   import vend_pkg::*;
#(
   parameter int unsigned NUM_DRINKS = 4,
   parameter int unsigned CREDIT_W   = 7,
   parameter int unsigned MAX_CREDIT = 100,
   parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICE_LIST =
      {CREDIT_W'(25), CREDIT_W'(20), CREDIT_W'(15), CREDIT_W'(10)},
   parameter int unsigned STOCK_INIT = 3
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          coin_valid,
   input  logic [CREDIT_W-1:0]           coin,
   input  logic                          drink_req,
   input  logic [$clog2(NUM_DRINKS)-1:0] drink_sel,
   input  logic                          restock,
`ifdef VEND_CANCEL_EN
   input  logic                          cancel,
`endif
   output logic [CREDIT_W-1:0]           total_coin,
   output logic                          coin_reject,
   output logic                          drink_out,
   output logic [$clog2(NUM_DRINKS)-1:0] drink_id,
   output logic                          vend_deny,
   output logic                          refund_valid,
   output logic [CREDIT_W-1:0]           refund,
   output logic [NUM_DRINKS-1:0]         sold_out,
   output logic                          busy
);

   localparam int unsigned SEL_W   = $clog2(NUM_DRINKS);
   localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);

   state_t              state, state_nx;
   logic [STOCK_W-1:0]  stock    [NUM_DRINKS];
   logic [STOCK_W-1:0]  stock_nx [NUM_DRINKS];

   logic [CREDIT_W-1:0] total_nx, refund_nx, price_c, next_coin_c;
   logic [SEL_W-1:0]    drink_id_nx;
   logic [STOCK_W-1:0]  stock_sel_c;
   logic [CREDIT_W:0]   sum_c;
   logic                coin_reject_nx, drink_out_nx, vend_deny_nx, refund_valid_nx;
   logic                sel_ok_c, coin_ok_c, req_ok_c, vend_go_c;

   vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change (
      .remainder   (total_coin),
      .next_coin_c (next_coin_c)
   );

   // Price and stock of the selected drink; out-of-range selects read as 0.
   always_comb begin
      price_c     = '0;
      stock_sel_c = '0;
      for (int i = 0; i < NUM_DRINKS; i++) begin
         if (SEL_W'(i) == drink_sel) begin
            price_c     = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            stock_sel_c = stock[i];
         end
      end
   end

   assign sel_ok_c  = 32'(drink_sel) < NUM_DRINKS;
   assign sum_c     = {1'b0, total_coin} + {1'b0, coin};
   assign coin_ok_c = is_legal_coin(32'(coin)) && (32'(sum_c) <= MAX_CREDIT);
   assign req_ok_c  = sel_ok_c && (stock_sel_c != '0) && (total_coin >= price_c);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_nx        = state;
      total_nx        = total_coin;
      coin_reject_nx  = 1'b0;
      drink_out_nx    = 1'b0;
      drink_id_nx     = drink_id;
      vend_deny_nx    = 1'b0;
      refund_valid_nx = 1'b0;
      refund_nx       = '0;
      vend_go_c       = 1'b0;
      case (state)
         IDLE, CREDIT: begin
`ifdef VEND_CANCEL_EN
            if (cancel && (state == CREDIT)) begin
               state_nx       = CHANGE;
               coin_reject_nx = coin_valid;
            end else
`endif
            if (drink_req) begin
               // A request wins over a same-cycle coin, which is returned.
               coin_reject_nx = coin_valid;
               if (req_ok_c) begin
                  state_nx     = VEND;
                  total_nx     = total_coin - price_c;
                  drink_out_nx = 1'b1;
                  drink_id_nx  = drink_sel;
                  vend_go_c    = 1'b1;
               end else begin
                  vend_deny_nx = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_ok_c) begin
                  total_nx = sum_c[CREDIT_W-1:0];
                  state_nx = CREDIT;
               end else begin
                  coin_reject_nx = 1'b1;
               end
            end
         end
         VEND: begin
            coin_reject_nx = coin_valid;
            state_nx       = (total_coin != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_reject_nx = coin_valid;
            if (total_coin != '0) begin
               refund_valid_nx = 1'b1;
               refund_nx       = next_coin_c;
               total_nx        = total_coin - next_coin_c;
            end
            if (total_nx == '0) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stock update: restock is applied after a same-cycle decrement.
   always_comb begin
      for (int i = 0; i < NUM_DRINKS; i++) begin
         stock_nx[i] = stock[i];
         if (vend_go_c && (drink_sel == SEL_W'(i))) stock_nx[i] = stock[i] - STOCK_W'(1);
         if (restock && (drink_sel == SEL_W'(i)))   stock_nx[i] = STOCK_W'(STOCK_INIT);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DRINKS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
         sold_out <= '0;
      end else begin
         for (int i = 0; i < NUM_DRINKS; i++) begin
            stock[i]    <= stock_nx[i];
            sold_out[i] <= (stock_nx[i] == '0);
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         total_coin   <= '0;
         coin_reject  <= 1'b0;
         drink_out    <= 1'b0;
         drink_id     <= '0;
         vend_deny    <= 1'b0;
         refund_valid <= 1'b0;
         refund       <= '0;
         busy         <= 1'b0;
      end else begin
         total_coin   <= total_nx;
         coin_reject  <= coin_reject_nx;
         drink_out    <= drink_out_nx;
         drink_id     <= drink_id_nx;
         vend_deny    <= vend_deny_nx;
         refund_valid <= refund_valid_nx;
         refund       <= refund_nx;
         busy         <= (state_nx == VEND) || (state_nx == CHANGE);
      end
   end

endmodule

// File: tb/tb_auto_vendor_multi.sv
// Self-checking bench for auto_vendor_multi (default parameters).
// Honours VEND_CANCEL_EN when defined.
module tb_auto_vendor_multi;

   localparam int ND   = 4;
   localparam int CW   = 7;
   localparam int MAXC = 100;
   localparam int SINIT = 3;
   localparam logic [ND*CW-1:0] PL = {7'd25, 7'd20, 7'd15, 7'd10};
`ifdef VEND_CANCEL_EN
   localparam bit CANCEL_EN = 1'b1;
`else
   localparam bit CANCEL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          coin_valid, drink_req, restock;
   logic [CW-1:0] coin;
   logic [1:0]    drink_sel;
`ifdef VEND_CANCEL_EN
   logic          cancel;
`endif
   logic [CW-1:0] total_coin, refund;
   logic          coin_reject, drink_out, vend_deny, refund_valid, busy;
   logic [1:0]    drink_id;
   logic [ND-1:0] sold_out;

   auto_vendor_multi dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .drink_req    (drink_req),
      .drink_sel    (drink_sel),
      .restock      (restock),
`ifdef VEND_CANCEL_EN
      .cancel       (cancel),
`endif
      .total_coin   (total_coin),
      .coin_reject  (coin_reject),
      .drink_out    (drink_out),
      .drink_id     (drink_id),
      .vend_deny    (vend_deny),
      .refund_valid (refund_valid),
      .refund       (refund),
      .sold_out     (sold_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int m_credit;
   int m_stock[ND];

   // Observed activity during one operation.
   int n_rej, n_deny, n_out, last_id;
   int obs_ref[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int price_of(input int i);
      logic [ND*CW-1:0] pl;
      pl = PL;
      return int'(pl[i*CW +: CW]);
   endfunction

   function automatic logic [ND-1:0] model_sold_out();
      logic [ND-1:0] s;
      for (int i = 0; i < ND; i++) s[i] = (m_stock[i] == 0);
      return s;
   endfunction

   // Change as denomination counts, largest first.
   task automatic change_list(input int amount, output int q[$]);
      int r;
      q = {};
      r = amount;
      repeat (r / 50) q.push_back(50);
      r = r % 50;
      repeat (r / 10) q.push_back(10);
      r = r % 10;
      repeat (r / 5) q.push_back(5);
      repeat (r % 5) q.push_back(1);
   endtask

   task automatic model_reset();
      m_credit = 0;
      for (int i = 0; i < ND; i++) m_stock[i] = SINIT;
   endtask

   task automatic sample();
      if (coin_reject) n_rej++;
      if (vend_deny)   n_deny++;
      if (drink_out) begin n_out++; last_id = int'(drink_id); end
      if (refund_valid) obs_ref.push_back(int'(refund));
      else check_val("refund_idle_zero", 32'(refund), 0);
   endtask

   task automatic drive_idle();
      coin_valid = 1'b0; coin = '0; drink_req = 1'b0; drink_sel = '0; restock = 1'b0;
`ifdef VEND_CANCEL_EN
      cancel = 1'b0;
`endif
   endtask

   // One operation: apply for one cycle, observe the response, compare to model.
   task automatic run_op(input string tag, input bit cv, input int cval, input bit rq,
                         input int sel, input bit rs, input bit cn);
      int e_rej, e_deny, e_out, e_id;
      int e_ref[$];
      e_rej = 0; e_deny = 0; e_out = 0; e_id = 0; e_ref = {};
      if (cn && CANCEL_EN && m_credit > 0) begin
         e_rej = cv ? 1 : 0;
         change_list(m_credit, e_ref);
         m_credit = 0;
      end else if (rq) begin
         e_rej = cv ? 1 : 0;
         if (sel < ND && m_stock[sel] > 0 && m_credit >= price_of(sel)) begin
            e_out = 1; e_id = sel;
            m_stock[sel]--;
            change_list(m_credit - price_of(sel), e_ref);
            m_credit = 0;
         end else e_deny = 1;
      end else if (cv) begin
         if (cval inside {1, 5, 10, 50} && m_credit + cval <= MAXC) m_credit += cval;
         else e_rej = 1;
      end
      if (rs && sel < ND) m_stock[sel] = SINIT;

      coin_valid = cv; coin = CW'(cval); drink_req = rq; drink_sel = 2'(sel); restock = rs;
`ifdef VEND_CANCEL_EN
      cancel = cn;
`endif
      n_rej = 0; n_deny = 0; n_out = 0; last_id = -1; obs_ref = {};
      @(posedge clk); #1;
      drive_idle();
      sample();
      repeat (15) begin @(posedge clk); #1; sample(); end

      check_val({tag, "_reject"}, 32'(n_rej), 32'(e_rej));
      check_val({tag, "_deny"},   32'(n_deny), 32'(e_deny));
      check_val({tag, "_out"},    32'(n_out), 32'(e_out));
      if (e_out != 0) check_val({tag, "_id"}, 32'(last_id), 32'(e_id));
      check_val({tag, "_nref"}, 32'(obs_ref.size()), 32'(e_ref.size()));
      for (int k = 0; k < e_ref.size() && k < obs_ref.size(); k++)
         check_val({tag, "_refund"}, 32'(obs_ref[k]), 32'(e_ref[k]));
      check_val({tag, "_credit"},  32'(total_coin), 32'(m_credit));
      check_val({tag, "_soldout"}, 32'(sold_out), 32'(model_sold_out()));
      check_val({tag, "_busy"},    32'(busy), 0);
   endtask

   task automatic coin_op(input string tag, input int v);
      run_op(tag, 1'b1, v, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic req_op(input string tag, input int s);
      run_op(tag, 1'b0, 0, 1'b1, s, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_total"},   32'(total_coin), 0);
      check_val({tag, "_rv"},      32'(refund_valid), 0);
      check_val({tag, "_refund"},  32'(refund), 0);
      check_val({tag, "_out"},     32'(drink_out), 0);
      check_val({tag, "_id"},      32'(drink_id), 0);
      check_val({tag, "_rej"},     32'(coin_reject), 0);
      check_val({tag, "_deny"},    32'(vend_deny), 0);
      check_val({tag, "_busy"},    32'(busy), 0);
      check_val({tag, "_soldout"}, 32'(sold_out), 0);
   endtask

   initial begin
      int coin_tab[8];
      int seen;
      bit got_first;
      coin_tab = '{1, 5, 10, 50, 7, 0, 25, 3};
      drive_idle();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Basic vend with change.
      coin_op("c10a", 10); coin_op("c10b", 10); coin_op("c5", 5);
      req_op("vend2", 2);

      // Illegal coin and credit ceiling.
      coin_op("coin7", 7);
      coin_op("c50", 50); coin_op("c10c", 10);
      coin_op("over_max", 50);
      req_op("vend3_change", 3);

      // Insufficient credit, then drain drink 0.
      coin_op("c10d", 10);
      req_op("deny_price", 3);
      req_op("vend0_a", 0);
      coin_op("c10e", 10); req_op("vend0_b", 0);
      coin_op("c10f", 10); req_op("vend0_c", 0);
      coin_op("c10g", 10); req_op("deny_sold", 0);
      run_op("restock0", 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
      req_op("vend0_after", 0);

      // Coin and request together.
      coin_op("c10h", 10);
      run_op("both", 1'b1, 10, 1'b1, 0, 1'b0, 1'b0);

      // Reset in the middle of change delivery (remainder 16).
      coin_op("m1", 10); coin_op("m2", 10); coin_op("m3", 10);
      coin_op("m4", 5);  coin_op("m5", 1);
      drink_req = 1'b1; drink_sel = 2'd2;
      @(posedge clk); #1;
      drive_idle();
      got_first = 1'b0;
      for (int c = 0; c < 10 && !got_first; c++) begin
         @(posedge clk); #1;
         if (refund_valid) got_first = 1'b1;
      end
      check_val("midchg_seen", 32'(got_first), 1);
      check_val("midchg_first", 32'(refund), 10);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midchg_rst");
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (refund_valid) seen++; end
      check_val("midchg_norefund", 32'(seen), 0);
      check_val("midchg_credit", 32'(total_coin), 0);

      if (CANCEL_EN) begin
         coin_op("k1", 10); coin_op("k2", 10); coin_op("k3", 10); coin_op("k4", 5);
         run_op("cancel", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
         run_op("cancel_idle", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      end

      // Randomized operations.
      for (int n = 0; n < 300; n++) begin
         int r, s;
         r = int'($urandom_range(0, 11));
         s = int'($urandom_range(0, ND - 1));
         if (r <= 4)      coin_op("rnd_coin", coin_tab[$urandom_range(0, 7)]);
         else if (r <= 7) req_op("rnd_req", s);
         else if (r == 8) run_op("rnd_both", 1'b1, coin_tab[$urandom_range(0, 7)], 1'b1, s, 1'b0, 1'b0);
         else if (r == 9) run_op("rnd_restock", 1'b0, 0, 1'(($urandom_range(0, 1))), s, 1'b1, 1'b0);
         else if (r == 10 && CANCEL_EN)
            run_op("rnd_cancel", 1'(($urandom_range(0, 1))), 10, 1'(($urandom_range(0, 1))), s, 1'b0, 1'b1);
         else coin_op("rnd_coin10", 10);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
